lcd_reader: RTL

- Read-side controller for the HD44780-style character LCD on the 8-bit parallel bus, clocked at 1 MHz. It complements the existing LCD write path.
- Performs single reads of the status register (busy flag + address counter, RS=0) or of DDRAM/CGRAM data (RS=1).
- Also performs an automatic busy-poll sequence that loops on status reads until BF=0 or a timeout expires.
- Sits between the LCD write FSM (or system controller) and the LCD pins; bus ownership between writer and reader is arbitrated outside this block via `bus_grant`.

---
 rtl/lcd_reader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_reader.sv
// lcd_reader: read-side controller for an HD44780-style character LCD on the
// 8-bit parallel bus. It performs single status/data reads and a busy-poll
// that repeats status reads until BF clears or the poll budget runs out.
module lcd_reader #(
    parameter int SETUP_CYC   = 1,
    parameter int EN_HIGH_CYC = 2,
    parameter int EN_LOW_CYC  = 2,
    parameter int POLL_MAX    = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus_grant,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       poll_req,
    input  logic [7:0] lcd_db_in,
    output logic       lcd_db_oe,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       poll_done,
    output logic       poll_timeout,
    output logic       rdr_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        EN_LO,
        CHECK
    } state_t;

    typedef enum logic {
        MODE_SINGLE,
        MODE_POLL
    } mode_t;

    // Last value of the phase counter in each timed state.
    localparam logic [7:0]  SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0]  EN_HI_LAST = 8'(EN_HIGH_CYC - 1);
    localparam logic [7:0]  EN_LO_LAST = 8'(EN_LOW_CYC - 1);
    // poll_cnt value during the final permitted status read, and its ceiling.
    localparam logic [10:0] POLL_LAST  = 11'(POLL_MAX - 1);
    localparam logic [10:0] POLL_SAT   = 11'(POLL_MAX);

    state_t      state, state_d;
    mode_t       mode, mode_d;
    logic [7:0]  phase_cnt, phase_cnt_d;
    logic [10:0] poll_cnt, poll_cnt_d;
    logic        rs_q, rs_d;
    logic [7:0]  cap_q;
    logic        capture_en;

    // The reader never drives the data pads.
    assign lcd_db_oe = 1'b0;

    // State, mode, latched RS and the phase/poll counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= MODE_SINGLE;
            phase_cnt <= '0;
            poll_cnt  <= '0;
            rs_q      <= 1'b0;
        end else begin
            state     <= state_d;
            mode      <= mode_d;
            phase_cnt <= phase_cnt_d;
            poll_cnt  <= poll_cnt_d;
            rs_q      <= rs_d;
        end
    end

    // Next-state logic: request acceptance, bus phase timing, poll decision.
    always_comb begin
        state_d     = state;
        mode_d      = mode;
        phase_cnt_d = phase_cnt;
        poll_cnt_d  = poll_cnt;
        rs_d        = rs_q;
        capture_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus_grant && (poll_req || rd_req)) begin
                    state_d     = SETUP;
                    phase_cnt_d = '0;
                    if (poll_req) begin
                        mode_d     = MODE_POLL;
                        rs_d       = 1'b0;
                        poll_cnt_d = '0;
                    end else begin
                        mode_d = MODE_SINGLE;
                        rs_d   = rd_rs;
                    end
                end
            end
            SETUP: begin
                if (phase_cnt == SETUP_LAST) begin
                    state_d     = EN_HI;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt + 8'd1;
                end
            end
            EN_HI: begin
                if (phase_cnt == EN_HI_LAST) begin
                    capture_en  = 1'b1;
                    state_d     = EN_LO;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt + 8'd1;
                end
            end
            EN_LO: begin
                if (phase_cnt == EN_LO_LAST) begin
                    state_d     = CHECK;
                    phase_cnt_d = '0;
                end else begin
                    phase_cnt_d = phase_cnt + 8'd1;
                end
            end
            CHECK: begin
                phase_cnt_d = '0;
                if (mode == MODE_SINGLE || !cap_q[7]) begin
                    state_d = IDLE;
                end else begin
                    if (poll_cnt != POLL_SAT) begin
                        poll_cnt_d = poll_cnt + 11'd1;
                    end
                    state_d = (poll_cnt == POLL_LAST) ? IDLE : SETUP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the LCD bus on the last EN-high cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q <= '0;
        end else if (capture_en) begin
            cap_q <= lcd_db_in;
        end
    end

    // Registered pins and result pulses, decoded from the upcoming state so
    // they line up with the state itself and are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_en       <= 1'b0;
            lcd_rw       <= 1'b0;
            lcd_rs       <= 1'b0;
            rdr_busy     <= 1'b0;
            rd_valid     <= 1'b0;
            poll_done    <= 1'b0;
            poll_timeout <= 1'b0;
            rd_data      <= '0;
            busy_flag    <= 1'b1;
            addr_cnt     <= '0;
        end else begin
            lcd_en       <= (state_d == EN_HI);
            lcd_rw       <= (state_d != IDLE);
            lcd_rs       <= (state_d != IDLE) && rs_d;
            rdr_busy     <= (state_d != IDLE);
            rd_valid     <= (state_d == CHECK);
            poll_done    <= (state_d == CHECK) && (mode == MODE_POLL) && !cap_q[7];
            poll_timeout <= (state_d == CHECK) && (mode == MODE_POLL) && cap_q[7]
                            && (poll_cnt == POLL_LAST);
            if (state_d == CHECK) begin
                rd_data <= cap_q;
                if (!rs_q) begin
                    busy_flag <= cap_q[7];
                    addr_cnt  <= cap_q[6:0];
                end
            end
        end
    end

endmodule
